// File: rtl/snn_image_loader_if.sv
// Handshake/bus bundle between the image source, the classifier core and snn_image_loader.
// The loader itself connects through the slave modport.
interface snn_image_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       start;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       done;
  logic [3:0] digit;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ack;

  modport master (
    output rx_data, rx_valid, addr_input_unit, done, digit, result_ack,
    input  rx_ready, start, q_input, result, result_valid
  );

  modport slave (
    input  rx_data, rx_valid, addr_input_unit, done, digit, result_ack,
    output rx_ready, start, q_input, result, result_valid
  );
endinterface

// File: rtl/snn_image_loader.sv
// Buffers one 784-pixel binary image (98 bytes), launches the classifier core and holds its result.
// Defining SNN_LOADER_TIMEOUT_EN adds a 16-bit RUN watchdog that reports 4'hF on expiry.
module snn_image_loader (
  input  logic              clk,
  input  logic              rst_n,
  snn_image_loader_if.slave bus
);
  localparam int         NUM_BYTES = 98;
  localparam logic [9:0] NUM_PIX   = 10'd784;
  localparam logic [6:0] LAST_BYTE = 7'd97;

  typedef enum logic [1:0] {LOAD, KICK, RUN, REPORT} state_t;

  state_t     state, state_nxt;
  logic [6:0] byte_cnt;
  logic [7:0] image [NUM_BYTES];
  logic       accept;
  logic       load_result;
  logic [3:0] result_nxt;
  logic       addr_ok;
  logic [6:0] rd_idx;
  logic [7:0] rd_byte;
  logic       pixel;
`ifdef SNN_LOADER_TIMEOUT_EN
  logic [15:0] wdog;
`endif

  // rx_ready is gated by rst_n so it reads 0 while reset is held
  always_comb begin
    state_nxt        = state;
    bus.rx_ready     = 1'b0;
    bus.start        = 1'b0;
    bus.result_valid = 1'b0;
    accept           = 1'b0;
    load_result      = 1'b0;
    result_nxt       = 4'h0;
    case (state)
      LOAD: begin
        bus.rx_ready = rst_n;
        accept       = rst_n && bus.rx_valid;
        if (accept && byte_cnt == LAST_BYTE) state_nxt = KICK;
      end
      KICK: begin
        bus.start = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.done) begin
          load_result = 1'b1;
          result_nxt  = bus.digit;
          state_nxt   = REPORT;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        else if (wdog == 16'hFFFF) begin
          load_result = 1'b1;
          result_nxt  = 4'hF;
          state_nxt   = REPORT;
        end
`endif
      end
      REPORT: begin
        bus.result_valid = 1'b1;
        if (bus.result_ack) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      byte_cnt   <= '0;
      bus.result <= 4'h0;
    end else begin
      state <= state_nxt;
      if (accept) byte_cnt <= (byte_cnt == LAST_BYTE) ? 7'd0 : byte_cnt + 7'd1;
      if (load_result) bus.result <= result_nxt;
    end
  end

`ifdef SNN_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wdog <= '0;
    else if (state == KICK)  wdog <= '0;
    else if (state == RUN)   wdog <= wdog + 16'd1;
  end
`endif

  // Image storage is not reset; only accepted LOAD bytes write it
  always_ff @(posedge clk) begin
    if (accept) image[byte_cnt] <= bus.rx_data;
  end

  assign addr_ok = bus.addr_input_unit < NUM_PIX;
  assign rd_idx  = addr_ok ? bus.addr_input_unit[9:3] : 7'd0;
  assign rd_byte = image[rd_idx];
  assign pixel   = addr_ok && rd_byte[bus.addr_input_unit[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.q_input <= 1'b0;
    else        bus.q_input <= pixel;
  end
endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: the driver updates an image/phase model and queues
// expected start cycles, pixel reads and results; monitors pop and compare as outputs appear.
module tb_snn_image_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  snn_image_loader_if bus ();
  snn_image_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: image contents plus whether the loader is currently collecting bytes
  logic [7:0] ref_img [98];
  bit  m_load = 1'b1;
  int  mcnt = 0;

  int start_q[$];
  bit rd_q[$];
  int res_q[$];

  logic rd_tag = 1'b0;
  logic tag_d = 1'b0;
  logic rv_prev = 1'b0;
  int   cur_res = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit ref_pix(int a);
    logic [7:0] b;
    if (a >= 784) return 1'b0;
    b = ref_img[a / 8];
    return b[a % 8];
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    tag_d <= rd_tag;
  end

  // Monitors
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      if (start_q.size() == 0) chk("unexpected_start", 1, 0);
      else chk("start_cycle", cyc, start_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (tag_d) begin
      if (rd_q.size() == 0) chk("read_queue_empty", 1, 0);
      else chk("q_input", bus.q_input, rd_q.pop_front());
    end
  end

  always @(negedge clk) begin
    int e;
    if (bus.result_valid === 1'b1) begin
      if (!rv_prev) begin
        if (res_q.size() == 0) chk("unexpected_result_valid", 1, 0);
        else begin
          e = res_q.pop_front();
          chk("result", bus.result, e);
          cur_res <= e;
        end
      end else begin
        chk("result_stable", bus.result, cur_res);
      end
    end
    rv_prev <= (bus.result_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit v);
    bus.rx_data  = d;
    bus.rx_valid = v;
    rd_tag       = 1'b0;
    if (v && m_load) begin
      ref_img[mcnt] = d;
      mcnt++;
      if (mcnt == 98) begin
        start_q.push_back(cyc + 1);
        m_load = 1'b0;
        mcnt   = 0;
      end
    end
    tick();
  endtask

  task automatic rd(input int a);
    bus.rx_valid        = 1'b0;
    bus.addr_input_unit = 10'(a);
    rd_tag              = 1'b1;
    rd_q.push_back(ref_pix(a));
    tick();
    rd_tag = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] d, input bit expected);
    bus.digit = d;
    bus.done  = 1'b1;
    if (expected) res_q.push_back(int'(d));
    tick();
    bus.done = 1'b0;
  endtask

  task automatic ack_result();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    m_load = 1'b1;
    mcnt   = 0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.done     = 1'b0;
    rd_tag       = 1'b0;
    rst_n        = 1'b0;
    m_load       = 1'b1;
    mcnt         = 0;
    tick();
    tick();
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_q_input", bus.q_input, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_release", bus.rx_ready, 1);
  endtask

  initial begin
    int k;
    bus.rx_data         = 8'h00;
    bus.rx_valid        = 1'b0;
    bus.addr_input_unit = 10'd0;
    bus.done            = 1'b0;
    bus.digit           = 4'h0;
    bus.result_ack      = 1'b0;

    do_reset();

    // Stray done and ack while loading are ignored
    pulse_done(4'd5, 1'b0);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk("rv_after_load_done", bus.result_valid, 0);
    chk("result_after_load_done", bus.result, 0);

    // Constant 8'hA5 image with rx_valid held high, then one byte too many
    for (int i = 0; i < 98; i++) send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    for (int a = 0; a < 8; a++) rd(a);
    rd(783); rd(784); rd(1023);
    chk("rx_ready_in_run", bus.rx_ready, 0);

    pulse_done(4'd7, 1'b1);
    repeat (20) tick();
    chk("rx_ready_in_report", bus.rx_ready, 0);
    pulse_done(4'd2, 1'b0);
    tick();
    ack_result();
    chk("rx_ready_after_ack", bus.rx_ready, 1);
    chk("rv_after_ack", bus.result_valid, 0);

    // Random image with rx_valid toggling every cycle
    k = 0;
    while (m_load) begin
      send_byte(8'($urandom), (k % 2) == 0);
      k++;
    end
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 40; i++) rd($urandom_range(0, 1023));
    for (int a = 776; a < 784; a++) rd(a);
    rd(784); rd(1023);
    pulse_done(4'd12, 1'b1);
    repeat (3) tick();
    ack_result();

    // Reset part-way through a load, then a fresh full load is required
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1'b1);
    do_reset();
    while (m_load) send_byte(8'($urandom), ($urandom % 4) != 0);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 30; i++) rd($urandom_range(0, 1023));
    rd(0); rd(783);
    pulse_done(4'($urandom), 1'b1);
    repeat (2) tick();
    ack_result();

    repeat (5) tick();
    chk("start_queue_drained", start_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snn_image_loader.md
SNN_IMAGE_LOADER -- requirements
Module: snn_image_loader

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rx_data  input  8  image byte carrying 8 pixels, LSB is the lowest pixel index
- rx_valid  input  1  rx_data is valid this cycle
- rx_ready  output  1  block accepts rx_data this cycle
- start  output  1  one-cycle pulse that launches the classifier core
- addr_input_unit  input  10  pixel address driven by the classifier core
- q_input  output  1  pixel value read at addr_input_unit
- done  input  1  classifier core completion pulse
- digit  input  4  classifier core result, sampled when done is high
- result  output  4  captured classification result
- result_valid  output  1  result is valid; held until acknowledged
- result_ack  input  1  consumer acknowledges result

Function
REQ-002 The block SHALL store one 784-pixel image as 98 bytes; pixel p SHALL be bit p[2:0] of byte p[9:3].
REQ-003 The FSM SHALL have the states LOAD, KICK, RUN and REPORT, and SHALL enter LOAD after reset.
REQ-004 In LOAD, rx_ready SHALL be 1; a byte SHALL be accepted on every cycle where rx_valid and rx_ready are both 1, and SHALL be written at the byte counter (0..97), which then increments.
REQ-005 On acceptance of byte 97, the FSM SHALL go to KICK on the next edge and the byte counter SHALL clear to 0.
REQ-006 In KICK, start SHALL be 1 for exactly one cycle, and the FSM SHALL then go to RUN.
REQ-007 In KICK, RUN and REPORT, rx_ready SHALL be 0, and the image SHALL NOT be modified.
REQ-008 q_input SHALL be registered with 1-cycle read latency: q_input at cycle n+1 SHALL equal the pixel at the addr_input_unit sampled at cycle n, in every state.
REQ-009 For addr_input_unit of 784 or more, q_input SHALL be 0 one cycle later.
REQ-010 In RUN, when done is 1, digit SHALL be captured into result and the FSM SHALL go to REPORT.
REQ-011 A done pulse in LOAD, KICK or REPORT SHALL be ignored and SHALL NOT change result.
REQ-012 In REPORT, result_valid SHALL be 1 and result SHALL be stable; when result_ack is 1, the FSM SHALL go to LOAD and result_valid SHALL fall on the same edge.
REQ-013 result_ack outside REPORT SHALL be ignored.
REQ-014 Bytes presented with rx_valid=1 while rx_ready=0 SHALL NOT be written, and SHALL NOT advance the counter.
REQ-015 Image contents SHALL persist after leaving LOAD; they SHALL be overwritten only by the next LOAD sequence.
REQ-016 A digit value greater than 9 SHALL be passed through unchanged.

Reset
REQ-017 On rst_n low, the state SHALL be LOAD and the byte counter SHALL be 0.
REQ-018 On rst_n low, the output reset values SHALL be: rx_ready=0 while reset is asserted and 1 in the first cycle after release, start=0, q_input=0, result=4'h0 and result_valid=0.
REQ-019 Image storage SHALL NOT be reset; its contents after reset are undefined until a LOAD completes.
REQ-020 A reset asserted during any state, including mid-LOAD or RUN, SHALL abort the operation, and a partial image SHALL NOT trigger start.

Configuration
REQ-021 When macro SNN_LOADER_TIMEOUT_EN is defined, a 16-bit watchdog SHALL clear on entry to RUN and SHALL increment each cycle in RUN.
REQ-022 With SNN_LOADER_TIMEOUT_EN defined, if the watchdog reaches 16'hFFFF without done, result SHALL be set to 4'hF and the FSM SHALL go to REPORT.
REQ-023 With SNN_LOADER_TIMEOUT_EN defined, if done arrives in the same cycle as the terminal count, done SHALL take priority.
REQ-024 When SNN_LOADER_TIMEOUT_EN is undefined, no watchdog logic SHALL exist, and RUN SHALL wait for done indefinitely.

Verification
REQ-025 Load test: stream 98 bytes of value 8'hA5 with rx_valid held high -> exactly 98 accepts and start high for one cycle, 1 cycle after the last accept; then addr 0..7 -> q_input 1,0,1,0,0,1,0,1, each delayed 1 cycle.
REQ-026 Backpressure test: toggle rx_valid 1/0 each cycle -> start only after the 98th valid byte; after start, an extra byte with rx_valid=1 is not accepted and the image is unchanged.
REQ-027 Result test: in RUN, pulse done with digit=4'd7 -> result=7 and result_valid=1 from the next cycle; hold result_ack=0 for 20 cycles -> result stays 7; then result_ack=1 -> FSM back in LOAD and rx_ready=1.
REQ-028 Boundary test: addr_input_unit=783 -> last pixel of byte 97; addr=784 and addr=1023 -> q_input 0; a done pulse in LOAD -> result_valid remains 0.
REQ-029 Reset test: assert rst_n low after 50 bytes -> all outputs at reset values; after release, 98 fresh bytes are needed before start.
REQ-030 Timeout test (SNN_LOADER_TIMEOUT_EN defined): no done for 65535 cycles in RUN -> result=4'hF and result_valid=1; repeat with done arriving in the terminal cycle with digit=3 -> result=3.
